memacc_engine: RTL and testbench
================================

Name: memacc_engine

Overview:
- Accumulator engine directly upstream of the 16K x 32 on-chip data memory; drives that memory's single-port interface as its only master.
- The Nios CPU programs it through an Avalon-MM CSR slave with a source word address, a length and a destination word address.
- It streams words out of the memory, sums them into a wide accumulator, and writes the low 32 bits of the sum back to memory. It then flags done and raises an IRQ.

Parameters:
- ADDR_W, 14, memory word-address width; addresses wrap modulo 2^ADDR_W.
- ACC_W, 40, accumulator width; must be 33..64.
- LEN_W, 15, length register width; max length 16384.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- csr_address  in  3  CSR word address.
- csr_chipselect  in  1  CSR select.
- csr_write  in  1  CSR write strobe.
- csr_read  in  1  CSR read strobe.
- csr_writedata  in  32  CSR write data.
- csr_readdata  out  32  CSR read data; read latency 0.
- irq  out  1  level interrupt; equals done AND ie.
- mem_address  out  ADDR_W  memory word address.
- mem_chipselect  out  1  memory select.
- mem_write  out  1  memory write.
- mem_byteenable  out  4  byte enables; always 4'hF.
- mem_writedata  out  32  write data.
- mem_clken  out  1  memory clock enable; constant 1.
- mem_readdata  in  32  memory read data; valid the cycle after the address is presented.

Behaviour:
- CSR map:
  - 0 CTRL/STATUS. Write: bit0 start, bit1 done-clear, bit2 ie. Read: bit0 busy, bit1 done, bit2 ie, bit3 overflow.
  - 1 SRC. 2 LEN. 3 DST.
  - 4 RESULT_LO = acc[31:0]. 5 RESULT_HI = acc[ACC_W-1:32] zero-extended.
  - 6, 7 read 0.
- Reset (async, reset_n=0): all registers 0, state IDLE. Outputs: mem_chipselect=0, mem_write=0, mem_address=0, irq=0, csr_readdata=0.
- Reset mid-operation aborts immediately. No writeback occurs; a partial result is lost.
- Writes to SRC/LEN/DST while busy are ignored. Start while busy is ignored.
- FSM IDLE -> RUN -> DRAIN -> WB -> IDLE.
  - IDLE: start=1 clears acc, overflow, done and the counter, and captures SRC/LEN/DST. The edge after start sets busy=1. LEN=0 goes straight to WB.
  - RUN: on cycle k, mem_chipselect=1, mem_write=0, mem_address=SRC+k (wrapping), for k=0..LEN-1. A registered rd_valid accompanies each issue. After issue LEN-1, go to DRAIN.
  - Accumulate: when rd_valid is set, acc <= acc + zero-extended mem_readdata. A carry out of bit ACC_W-1 sets sticky overflow; acc wraps.
  - DRAIN: one cycle with no issue; the last word is accumulated here.
  - WB: one cycle with mem_chipselect=1, mem_write=1, mem_address=DST, mem_writedata=acc[31:0]. The next edge sets done=1 and busy=0 and returns to IDLE.
- Total busy cycles: LEN+2 for LEN>0, 1 for LEN=0.
- done stays set until a done-clear write or a new start. Done-clear and start in the same write: start wins, done=0.
- DST inside the source range is allowed, because the writeback happens after all reads.

Optional Feature:
- Macro MEMACC_SIGNED_EN.
- Defined: each word is sign-extended before accumulation. Overflow means signed overflow, i.e. the carry into the MSB differs from the carry out. RESULT_HI is sign-extended from acc[ACC_W-1].
- Undefined: unsigned accumulation as above.

Decomposition:
- Package memacc_pkg holds the FSM state enum, the CSR offset constants (CSR_CTRL..CSR_RES_HI), the CTRL bit indices and the default widths.
- One sub-module, memacc_csr: CSR registers, readback mux, start/done-clear pulses and irq.
- Top memacc_engine holds the FSM, address counter and accumulator.

Test Plan:
- Memory words 0..3 = 1,2,3,4; SRC=0, LEN=4, DST=100, start -> busy for 6 cycles; mem[100]=10; RESULT_LO=10; done=1; irq=1 with ie=1.
- LEN=0, start -> busy 1 cycle; mem[DST]=0; done=1.
- SRC=16382, LEN=4, words 16382, 16383, 0, 1 = 0xFFFFFFFF each -> addresses wrap to 0; RESULT_HI=3, RESULT_LO=0xFFFFFFFC; overflow=0.
- Start again mid-run, plus a write to SRC -> both ignored; the result matches the original programming.
- reset_n dropped in RUN -> outputs immediately 0, no write to DST; a fresh start afterwards works.
- MEMACC_SIGNED_EN, words -1,-1,2 -> RESULT_LO=0, RESULT_HI=0, mem[DST]=0.

Source files
------------

// File: rtl/memacc_pkg.sv
// Shared types and constants for the memacc_engine accumulator slice.
// This package holds the FSM states, the CSR offsets, the CTRL/STATUS bit indices and the default widths.
package memacc_pkg;

  localparam int DEF_ADDR_W = 14;
  localparam int DEF_ACC_W  = 40;
  localparam int DEF_LEN_W  = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_WB    = 2'd3
  } state_t;

  localparam logic [2:0] CSR_CTRL   = 3'd0;
  localparam logic [2:0] CSR_SRC    = 3'd1;
  localparam logic [2:0] CSR_LEN    = 3'd2;
  localparam logic [2:0] CSR_DST    = 3'd3;
  localparam logic [2:0] CSR_RES_LO = 3'd4;
  localparam logic [2:0] CSR_RES_HI = 3'd5;

  localparam int CTRL_START    = 0;
  localparam int CTRL_DONE_CLR = 1;
  localparam int CTRL_IE       = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_IE   = 2;
  localparam int STAT_OVF  = 3;

endpackage

// File: rtl/memacc_if.sv
// Bus bundles of memacc_engine: the Avalon-MM CSR port driven by the CPU and
// the single-port data-memory port that the engine masters.
interface memacc_csr_if;
  logic [2:0]  csr_address;
  logic        csr_chipselect;
  logic        csr_write;
  logic        csr_read;
  logic [31:0] csr_writedata;
  logic [31:0] csr_readdata;
  logic        irq;

  modport master (
    output csr_address, csr_chipselect, csr_write, csr_read, csr_writedata,
    input  csr_readdata, irq
  );
  modport slave (
    input  csr_address, csr_chipselect, csr_write, csr_read, csr_writedata,
    output csr_readdata, irq
  );
endinterface

interface memacc_mem_if #(parameter int ADDR_W = 14);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_chipselect;
  logic              mem_write;
  logic [3:0]        mem_byteenable;
  logic [31:0]       mem_writedata;
  logic              mem_clken;
  logic [31:0]       mem_readdata;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
    input  mem_readdata
  );
  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable, mem_writedata, mem_clken,
    output mem_readdata
  );
endinterface

// File: rtl/memacc_csr.sv
// CSR block of memacc_engine: programming registers, readback, start pulse, done and irq.
// With MEMACC_SIGNED_EN defined, RESULT_HI is sign-extended instead of zero-extended.
module memacc_csr
  import memacc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              reset_n,
  memacc_csr_if.slave       csr,
  input  logic              i_busy,
  input  logic              i_done_set,
  input  logic              i_overflow,
  input  logic [ACC_W-1:0]  i_acc,
  output logic              o_start,
  output logic [ADDR_W-1:0] o_src,
  output logic [LEN_W-1:0]  o_len,
  output logic [ADDR_W-1:0] o_dst
);

  logic              w_wr;
  logic              w_ctrl_wr;
  logic [63:0]       w_acc64;
  logic              w_unused_wdata;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic              r_ie;
  logic              r_done;

  assign w_wr           = csr.csr_chipselect & csr.csr_write;
  assign w_ctrl_wr      = w_wr && (csr.csr_address == CSR_CTRL);
  assign o_start        = w_ctrl_wr & csr.csr_writedata[CTRL_START] & ~i_busy;
  assign w_unused_wdata = &{1'b0, csr.csr_writedata};

  assign o_src   = r_src;
  assign o_len   = r_len;
  assign o_dst   = r_dst;
  assign csr.irq = r_done & r_ie;

`ifdef MEMACC_SIGNED_EN
  assign w_acc64 = 64'($signed(i_acc));
`else
  assign w_acc64 = 64'(i_acc);
`endif

  // Programming registers are frozen while a job runs; start also wins over done-clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src  <= '0;
      r_len  <= '0;
      r_dst  <= '0;
      r_ie   <= 1'b0;
      r_done <= 1'b0;
    end else begin
      if (w_wr && !i_busy) begin
        case (csr.csr_address)
          CSR_SRC: r_src <= csr.csr_writedata[ADDR_W-1:0];
          CSR_LEN: r_len <= csr.csr_writedata[LEN_W-1:0];
          CSR_DST: r_dst <= csr.csr_writedata[ADDR_W-1:0];
          default: ;
        endcase
      end
      if (w_ctrl_wr)
        r_ie <= csr.csr_writedata[CTRL_IE];
      if (o_start)
        r_done <= 1'b0;
      else if (i_done_set)
        r_done <= 1'b1;
      else if (w_ctrl_wr && csr.csr_writedata[CTRL_DONE_CLR])
        r_done <= 1'b0;
    end
  end

  always_comb begin
    csr.csr_readdata = '0;
    if (csr.csr_chipselect && csr.csr_read) begin
      case (csr.csr_address)
        CSR_CTRL: begin
          csr.csr_readdata[STAT_BUSY] = i_busy;
          csr.csr_readdata[STAT_DONE] = r_done;
          csr.csr_readdata[STAT_IE]   = r_ie;
          csr.csr_readdata[STAT_OVF]  = i_overflow;
        end
        CSR_SRC:    csr.csr_readdata = 32'(r_src);
        CSR_LEN:    csr.csr_readdata = 32'(r_len);
        CSR_DST:    csr.csr_readdata = 32'(r_dst);
        CSR_RES_LO: csr.csr_readdata = w_acc64[31:0];
        CSR_RES_HI: csr.csr_readdata = w_acc64[63:32];
        default:    csr.csr_readdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/memacc_engine.sv
// Memory accumulator: streams LEN words from SRC, sums them, writes the low word to DST.
// MEMACC_SIGNED_EN selects signed accumulation with signed-overflow detection.
module memacc_engine
  import memacc_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic         clk,
  input  logic         reset_n,
  memacc_csr_if.slave  csr,
  memacc_mem_if.master mem
);

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-1:0] r_src;
  logic [ADDR_W-1:0] r_dst;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [ACC_W-1:0]  r_acc;
  logic              r_ovf;
  logic              r_rd_valid;

  logic              w_start;
  logic              w_busy;
  logic              w_done_set;
  logic              w_last_issue;
  logic [ADDR_W-1:0] w_src_cfg;
  logic [ADDR_W-1:0] w_dst_cfg;
  logic [LEN_W-1:0]  w_len_cfg;
  logic [ACC_W-1:0]  w_word;
  logic [ACC_W-1:0]  w_sum;
  logic              w_ovf;

  memacc_csr #(
    .ADDR_W(ADDR_W),
    .ACC_W (ACC_W),
    .LEN_W (LEN_W)
  ) u_csr (
    .clk       (clk),
    .reset_n   (reset_n),
    .csr       (csr),
    .i_busy    (w_busy),
    .i_done_set(w_done_set),
    .i_overflow(r_ovf),
    .i_acc     (r_acc),
    .o_start   (w_start),
    .o_src     (w_src_cfg),
    .o_len     (w_len_cfg),
    .o_dst     (w_dst_cfg)
  );

  assign w_busy         = (r_state != ST_IDLE);
  assign w_last_issue   = ((r_cnt + LEN_W'(1)) == r_len);
  assign mem.mem_byteenable = 4'hF;
  assign mem.mem_clken      = 1'b1;

  // Signed overflow: both addends share a sign that the sum does not.
`ifdef MEMACC_SIGNED_EN
  assign w_word = ACC_W'($signed(mem.mem_readdata));
  assign w_sum  = r_acc + w_word;
  assign w_ovf  = (r_acc[ACC_W-1] == w_word[ACC_W-1]) && (w_sum[ACC_W-1] != r_acc[ACC_W-1]);
`else
  logic w_carry;
  assign w_word           = ACC_W'(mem.mem_readdata);
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, w_word};
  assign w_ovf            = w_carry;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_state <= ST_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next             = r_state;
    w_done_set         = 1'b0;
    mem.mem_chipselect = 1'b0;
    mem.mem_write      = 1'b0;
    mem.mem_address    = '0;
    mem.mem_writedata  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_start)
          w_next = (w_len_cfg == '0) ? ST_WB : ST_RUN;
      end
      ST_RUN: begin
        mem.mem_chipselect = 1'b1;
        mem.mem_address    = r_src + r_cnt[ADDR_W-1:0];
        if (w_last_issue)
          w_next = ST_DRAIN;
      end
      ST_DRAIN: w_next = ST_WB;
      ST_WB: begin
        mem.mem_chipselect = 1'b1;
        mem.mem_write      = 1'b1;
        mem.mem_address    = r_dst;
        mem.mem_writedata  = r_acc[31:0];
        w_done_set         = 1'b1;
        w_next             = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // rd_valid trails each issue by one cycle, matching the memory's read latency.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_src      <= '0;
      r_dst      <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_acc      <= '0;
      r_ovf      <= 1'b0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= (r_state == ST_RUN);
      if (w_start) begin
        r_src <= w_src_cfg;
        r_dst <= w_dst_cfg;
        r_len <= w_len_cfg;
        r_cnt <= '0;
        r_acc <= '0;
        r_ovf <= 1'b0;
      end else begin
        if (r_state == ST_RUN)
          r_cnt <= r_cnt + LEN_W'(1);
        if (r_rd_valid) begin
          r_acc <= w_sum;
          if (w_ovf)
            r_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_memacc_engine.sv
// Self-checking bench for memacc_engine: directed scenarios plus randomized jobs
// checked against an arithmetic model of the accumulation over a behavioural memory.
module tb_memacc_engine;
  import memacc_pkg::*;

  localparam int AW    = 14;
  localparam int ACCW  = 40;
  localparam int DEPTH = 1 << AW;
  localparam longint ACC_SPAN = longint'(1) << ACCW;
  localparam longint ACC_MAX  = (longint'(1) << (ACCW - 1)) - 1;
  localparam longint ACC_MIN  = -(longint'(1) << (ACCW - 1));

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  memacc_csr_if csrBus();
  memacc_mem_if #(.ADDR_W(AW)) memBus();

  memacc_engine #(
    .ADDR_W(AW),
    .ACC_W (ACCW),
    .LEN_W (15)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .csr    (csrBus),
    .mem    (memBus)
  );

  logic [31:0]   mem [DEPTH];
  int            wrCount = 0;
  logic [AW-1:0] lastWrAddr = '0;
  logic [3:0]    lastWrBe = '0;

  // Behavioural single-port memory with one cycle of read latency
  always @(posedge clk) begin
    if (memBus.mem_chipselect && memBus.mem_clken) begin
      if (memBus.mem_write) begin
        mem[memBus.mem_address] = memBus.mem_writedata;
        wrCount    = wrCount + 1;
        lastWrAddr = memBus.mem_address;
        lastWrBe   = memBus.mem_byteenable;
      end
      memBus.mem_readdata <= mem[memBus.mem_address];
    end
  end

  int checkCount = 0;
  int passCount  = 0;
  logic [ACCW-1:0] expAcc;
  logic            expOvf;
  logic [31:0]     expHi;
  logic [31:0]     lastLo;
  logic [31:0]     lastHi;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed === expected)
      passCount++;
    else
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
  endtask

  // Reference: sum the words the job will read, then derive the wrapped result and overflow
  function automatic void modelRun(input int src, input int len);
    logic [63:0] ext;
`ifdef MEMACC_SIGNED_EN
    longint acc;
    bit     ovf;
    acc = 0;
    ovf = 0;
    for (int k = 0; k < len; k++) begin
      longint w;
      w   = longint'($signed(mem[(src + k) % DEPTH]));
      acc = acc + w;
      if (acc > ACC_MAX) begin ovf = 1; acc = acc - ACC_SPAN; end
      if (acc < ACC_MIN) begin ovf = 1; acc = acc + ACC_SPAN; end
    end
    expAcc = acc[ACCW-1:0];
    expOvf = ovf;
    ext    = {{(64 - ACCW){expAcc[ACCW-1]}}, expAcc};
`else
    longint unsigned s;
    s = 0;
    for (int k = 0; k < len; k++)
      s = s + longint'(mem[(src + k) % DEPTH]);
    expAcc = s[ACCW-1:0];
    expOvf = ((s >> ACCW) != 0);
    ext    = {{(64 - ACCW){1'b0}}, expAcc};
`endif
    expHi = ext[63:32];
  endfunction

  task automatic csrWrite(input logic [2:0] addr, input logic [31:0] data);
    @(negedge clk);
    csrBus.csr_address    = addr;
    csrBus.csr_writedata  = data;
    csrBus.csr_chipselect = 1'b1;
    csrBus.csr_write      = 1'b1;
    csrBus.csr_read       = 1'b0;
    @(negedge clk);
    csrBus.csr_chipselect = 1'b0;
    csrBus.csr_write      = 1'b0;
  endtask

  task automatic csrRead(input logic [2:0] addr, output logic [31:0] data);
    csrBus.csr_address    = addr;
    csrBus.csr_chipselect = 1'b1;
    csrBus.csr_read       = 1'b1;
    #1;
    data = csrBus.csr_readdata;
    csrBus.csr_chipselect = 1'b0;
    csrBus.csr_read       = 1'b0;
  endtask

  task automatic waitIdle(input string tag);
    logic [31:0] rd;
    bit finished;
    finished = 0;
    for (int i = 0; i < 20000; i++) begin
      csrRead(CSR_CTRL, rd);
      if (!rd[STAT_BUSY]) begin finished = 1; break; end
      @(negedge clk);
    end
    checkOutput(tag, 64'(finished), 64'd1);
  endtask

  // Program, start, measure busy length and check every visible result against the model
  task automatic applyStimulus(input int src, input int len, input int dst, input bit poke, input int expBusy);
    logic [31:0] rd;
    int  busyCycles;
    int  wr0;
    bit  finished;
    csrWrite(CSR_SRC, 32'(src));
    csrWrite(CSR_LEN, 32'(len));
    csrWrite(CSR_DST, 32'(dst));
    modelRun(src, len);
    wr0 = wrCount;
    csrWrite(CSR_CTRL, 32'h5);
    busyCycles = 0;
    finished   = 0;
    for (int i = 0; i < 20000; i++) begin
      csrRead(CSR_CTRL, rd);
      if (!rd[STAT_BUSY]) begin finished = 1; break; end
      busyCycles++;
      if (poke && i == 0) begin
        csrWrite(CSR_SRC, 32'((src + 5) % DEPTH));
        csrWrite(CSR_CTRL, 32'h5);
      end
      @(negedge clk);
    end
    checkOutput("jobFinished", 64'(finished), 64'd1);
    if (expBusy >= 0)
      checkOutput("busyCycles", 64'(busyCycles), 64'(expBusy));
    csrRead(CSR_CTRL, rd);
    checkOutput("status", 64'(rd[3:0]), 64'({expOvf, 3'b110}));
    checkOutput("irqDone", 64'(csrBus.irq), 64'd1);
    checkOutput("writeCount", 64'(wrCount - wr0), 64'd1);
    checkOutput("writeAddr", 64'(lastWrAddr), 64'(dst % DEPTH));
    checkOutput("writeBe", 64'(lastWrBe), 64'hF);
    checkOutput("memDst", 64'(mem[dst % DEPTH]), 64'(expAcc[31:0]));
    csrRead(CSR_RES_LO, rd);
    lastLo = rd;
    checkOutput("resultLo", 64'(rd), 64'(expAcc[31:0]));
    csrRead(CSR_RES_HI, rd);
    lastHi = rd;
    checkOutput("resultHi", 64'(rd), 64'(expHi));
    if (poke) begin
      csrRead(CSR_SRC, rd);
      checkOutput("srcHeld", 64'(rd), 64'(src));
    end
  endtask

  initial begin
    logic [31:0] rd;
    int wr0;
    int src;
    int len;
    int dst;

    csrBus.csr_address    = '0;
    csrBus.csr_chipselect = 1'b0;
    csrBus.csr_write      = 1'b0;
    csrBus.csr_read       = 1'b0;
    csrBus.csr_writedata  = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = 32'h0;

    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #1;
    checkOutput("rstChipselect", 64'(memBus.mem_chipselect), 64'd0);
    checkOutput("rstWrite", 64'(memBus.mem_write), 64'd0);
    checkOutput("rstAddress", 64'(memBus.mem_address), 64'd0);
    checkOutput("rstIrq", 64'(csrBus.irq), 64'd0);
    csrRead(CSR_CTRL, rd);
    checkOutput("rstStatus", 64'(rd), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    $display("[TB] basic 4-word job");
    for (int i = 0; i < 4; i++) mem[i] = 32'(i + 1);
    applyStimulus(0, 4, 100, 0, 6);
    checkOutput("basicLo", 64'(lastLo), 64'd10);

    csrWrite(CSR_CTRL, 32'h6);
    csrRead(CSR_CTRL, rd);
    checkOutput("doneCleared", 64'(rd[STAT_DONE]), 64'd0);
    checkOutput("irqCleared", 64'(csrBus.irq), 64'd0);

    $display("[TB] zero-length job");
    mem[200] = 32'hDEADBEEF;
    applyStimulus(0, 0, 200, 0, 1);

    $display("[TB] address wrap");
    mem[16382] = 32'hFFFFFFFF; mem[16383] = 32'hFFFFFFFF;
    mem[0] = 32'hFFFFFFFF;     mem[1] = 32'hFFFFFFFF;
    applyStimulus(16382, 4, 300, 0, 6);
`ifndef MEMACC_SIGNED_EN
    checkOutput("wrapHi", 64'(lastHi), 64'd3);
    checkOutput("wrapLo", 64'(lastLo), 64'hFFFFFFFC);
`endif

    csrWrite(CSR_CTRL, 32'h7);
    csrRead(CSR_CTRL, rd);
    checkOutput("startBeatsClear", 64'(rd[2:0]), 64'b101);
    waitIdle("restartIdle");

    $display("[TB] start and SRC write during a run");
    for (int i = 1000; i < 1030; i++) mem[i] = $urandom;
    applyStimulus(1000, 30, 1010, 1, -1);

    $display("[TB] accumulator overflow");
    for (int i = 2000; i < 2300; i++) mem[i] = 32'hFFFFFFFF;
    applyStimulus(2000, 300, 5000, 0, 302);

`ifdef MEMACC_SIGNED_EN
    mem[4000] = 32'hFFFFFFFF; mem[4001] = 32'hFFFFFFFF; mem[4002] = 32'h2;
    applyStimulus(4000, 3, 4100, 0, 5);
    checkOutput("signedLo", 64'(lastLo), 64'd0);
    checkOutput("signedHi", 64'(lastHi), 64'd0);
`endif

    $display("[TB] reset during run");
    for (int i = 3000; i < 3020; i++) mem[i] = $urandom;
    mem[3500] = 32'h12345678;
    csrWrite(CSR_SRC, 32'd3000);
    csrWrite(CSR_LEN, 32'd20);
    csrWrite(CSR_DST, 32'd3500);
    wr0 = wrCount;
    csrWrite(CSR_CTRL, 32'h5);
    repeat (3) @(negedge clk);
    checkOutput("runChipselect", 64'(memBus.mem_chipselect), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("abortChipselect", 64'(memBus.mem_chipselect), 64'd0);
    checkOutput("abortWrite", 64'(memBus.mem_write), 64'd0);
    checkOutput("abortAddress", 64'(memBus.mem_address), 64'd0);
    checkOutput("abortIrq", 64'(csrBus.irq), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    checkOutput("abortNoWrite", 64'(wrCount - wr0), 64'd0);
    checkOutput("abortDstKept", 64'(mem[3500]), 64'h12345678);
    csrRead(CSR_CTRL, rd);
    checkOutput("abortStatus", 64'(rd), 64'd0);
    applyStimulus(3000, 20, 3500, 0, 22);

    $display("[TB] randomized jobs");
    for (int r = 0; r < 8; r++) begin
      src = int'($urandom_range(0, DEPTH - 1));
      len = int'($urandom_range(1, 24));
      dst = int'($urandom_range(0, DEPTH - 1));
      for (int k = 0; k < len; k++)
        mem[(src + k) % DEPTH] = (r % 2 == 0) ? $urandom : (32'hFFFF0000 | 32'($urandom_range(0, 65535)));
      applyStimulus(src, len, dst, 0, len + 2);
    end

    csrRead(3'd6, rd);
    checkOutput("reserved6", 64'(rd), 64'd0);
    csrRead(3'd7, rd);
    checkOutput("reserved7", 64'(rd), 64'd0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
